forward_scoreboard: RTL and testbench
=====================================

Name: forward_scoreboard

Overview:
- Parametrised forwarding and load-use hazard unit for the pipelined datapath.
- Tracks the destination registers of DEPTH in-flight instructions in a shifting scoreboard that advances with the pipeline.
- Produces a per-operand forward select for NSRC source operands and a load-use stall request.
- Sits beside the ID/EX boundary; the ALU operand muxes consume fwd_sel, and the hazard/PC logic consumes hazard_stall.

Parameters:
- REG_W, 5, register index width
- NSRC, 2, number of source operands checked per issuing instruction
- DEPTH, 3, in-flight stages tracked (entry 0 = EX/MEM, entry 1 = MEM/WB, entry 2 = WB)
- LOAD_LAT, 1, minimum entry index at which load data is forwardable (0..DEPTH-1)
- CNT_W, 16, width of hazard stall counter
- SEL_W, $clog2(DEPTH+1), derived, forward select width

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous active-high reset
- issue_valid  input  1  instruction in ID/EX is real (not a bubble)
- issue_rd  input  REG_W  destination register of issuing instruction
- issue_regW  input  1  issuing instruction writes a register
- issue_load  input  1  issuing instruction is a load
- src_regs  input  NSRC*REG_W  source register indices; operand k occupies bits [k*REG_W +: REG_W]
- src_used  input  NSRC  operand k is actually read (R-type/I-type enable per operand)
- stall_in  input  1  external freeze (memory wait); scoreboard holds
- flush  input  1  squash the instruction in ID/EX
- fwd_sel  output  NSRC*SEL_W  per operand: 0 = register file, j+1 = forward from entry j
- hazard_stall  output  1  load-use hazard; hold ID/EX and insert bubble
- hazard_count  output  CNT_W  saturating count of cycles with hazard_stall asserted

Behaviour:
- Storage: DEPTH entries {valid, rd, regW, load}.
  - An entry is "live" when valid && regW && rd != 0.
  - Register 0 is never tracked and never forwarded.
- Reset (RST high at a CLK edge):
  - all entries invalid, hazard_count = 0;
  - consequently fwd_sel = 0 and hazard_stall = 0 in the cycle after reset.
  - Reset applied mid-stream discards all in-flight records.
- Forward select (combinational from entry state plus current src inputs):
  - For operand k with src_used[k] = 1 and src != 0, find the lowest index j (youngest) whose live entry has rd == src.
  - If there is no match, or src_used[k] = 0, or src == 0: sel = 0.
  - If the match is ready (load == 0, or j >= LOAD_LAT): sel = j+1.
  - If the match is a load with j < LOAD_LAT: sel = 0 and the operand is hazarded.
  - An older match never overrides a younger one, even when the younger is a not-ready load.
- hazard_stall = issue_valid && (any operand hazarded) && !flush.
- Update at CLK edge, priority highest first:
  1. RST: clear all entries and hazard_count.
  2. stall_in = 1: entries 1..DEPTH-1 hold. Entry 0 holds, except flush = 1 forces entry 0 invalid. hazard_count holds.
  3. Otherwise the pipeline shifts: entry j+1 <= entry j, and the oldest entry retires.
     - entry 0 <= issuing instruction if issue_valid && !hazard_stall && !flush;
     - otherwise entry 0 <= bubble (valid = 0).
  4. hazard_count increments by 1 on each edge where RST = 0, stall_in = 0 and hazard_stall = 1; it saturates at 2^CNT_W - 1.
- Latency and resolution:
  - fwd_sel is same-cycle (zero latency); the scoreboard update has a one-cycle latency.
  - A load-use hazard with LOAD_LAT = 1 stalls exactly one cycle.
  - General case: LOAD_LAT - j cycles, where j is the load's entry index.
- Simultaneous events:
  - flush and hazard_stall together: flush wins, hazard_stall = 0, bubble inserted.
  - Operands matching different entries resolve independently.
  - Both operands naming the same register get identical selects.

Test Plan:
1. Reset, then issue add rd=8 with regW=1; next cycle issue operand0 = 8, used -> fwd_sel[0] = 1, fwd_sel[1] = 0, hazard_stall = 0.
2. Issue lw rd=9; next cycle issue a consumer with src1 = 9 (LOAD_LAT = 1) -> hazard_stall = 1 for exactly one cycle, hazard_count = 1; the following cycle fwd_sel[1] = 2, hazard_stall = 0.
3. Issue writes to r5 in consecutive cycles (add, then sub); consumer with src0 = 5 -> fwd_sel[0] = 1 (youngest). Two bubbles later, a consumer of r5 -> fwd_sel[0] = 3, then 0 once the entry retires.
4. rd = 0 with regW = 1, consumer with src = 0 -> fwd_sel = 0. A consumer with src_used = 0 matching a live entry -> fwd_sel = 0, no stall.
5. stall_in held 3 cycles with entry 0 = lw r9 and a pending consumer of r9 -> entries frozen, hazard_count unchanged. flush during stall_in -> entry 0 invalid, hazard_stall drops to 0.
6. Force the counter to 2^CNT_W - 2 (CNT_W = 2 build), then 3 hazard cycles -> count saturates at 3. Assert RST mid-hazard -> all selects 0, hazard_stall = 0, count = 0 next cycle.

Source files
------------

// File: rtl/forward_scoreboard.sv
// Forwarding and load-use hazard unit: a shifting record of in-flight destination
// registers that yields per-operand bypass selects and a load-use stall request.
module forward_scoreboard #(
    parameter int REG_W    = 5,
    parameter int NSRC     = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    issue_valid,
    input  logic [REG_W-1:0]        issue_rd,
    input  logic                    issue_regW,
    input  logic                    issue_load,
    input  logic [NSRC*REG_W-1:0]   src_regs,
    input  logic [NSRC-1:0]         src_used,
    input  logic                    stall_in,
    input  logic                    flush,
    output logic [NSRC*SEL_W-1:0]   fwd_sel,
    output logic                    hazard_stall,
    output logic [CNT_W-1:0]        hazard_count
);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0]             regw_q, regw_d;
    logic [DEPTH-1:0]             load_q, load_d;
    logic [DEPTH-1:0][REG_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]             hazard_count_q, hazard_count_d;

    logic [DEPTH-1:0]             live_s;
    logic [NSRC-1:0]              hit_s;
    logic [NSRC-1:0]              op_hazard_s;
    logic [NSRC*SEL_W-1:0]        fwd_sel_s;
    logic                         hazard_stall_s;

    // Entries that actually produce a forwardable register value (r0 never tracked)
    always_comb begin
        live_s = '0;
        for (int j = 0; j < DEPTH; j++) begin
            live_s[j] = valid_q[j] && regw_q[j] && (rd_q[j] != {REG_W{1'b0}});
        end
    end

    // Per-operand search from youngest to oldest; the first hit decides, even a not-ready load
    always_comb begin
        hit_s       = '0;
        op_hazard_s = '0;
        fwd_sel_s   = '0;
        for (int k = 0; k < NSRC; k++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (!hit_s[k] && src_used[k] &&
                    (src_regs[k*REG_W +: REG_W] != {REG_W{1'b0}}) &&
                    live_s[j] && (rd_q[j] == src_regs[k*REG_W +: REG_W])) begin
                    hit_s[k] = 1'b1;
                    if (load_q[j] && (j < LOAD_LAT)) begin
                        op_hazard_s[k] = 1'b1;
                    end else begin
                        fwd_sel_s[k*SEL_W +: SEL_W] = SEL_W'(j + 1);
                    end
                end else begin
                    hit_s[k] = hit_s[k];
                end
            end
        end
        hazard_stall_s = issue_valid && (|op_hazard_s) && !flush;
    end

    // Scoreboard advance: freeze on stall_in (flush still kills entry 0), else shift
    always_comb begin
        valid_d        = valid_q;
        regw_d         = regw_q;
        load_d         = load_q;
        rd_d           = rd_q;
        hazard_count_d = hazard_count_q;
        if (stall_in) begin
            if (flush) begin
                valid_d[0] = 1'b0;
            end else begin
                valid_d[0] = valid_q[0];
            end
        end else begin
            for (int j = DEPTH - 1; j > 0; j--) begin
                valid_d[j] = valid_q[j-1];
                regw_d[j]  = regw_q[j-1];
                load_d[j]  = load_q[j-1];
                rd_d[j]    = rd_q[j-1];
            end
            valid_d[0] = issue_valid && !hazard_stall_s && !flush;
            regw_d[0]  = issue_regW;
            load_d[0]  = issue_load;
            rd_d[0]    = issue_rd;
            if (hazard_stall_s && (hazard_count_q != {CNT_W{1'b1}})) begin
                hazard_count_d = hazard_count_q + CNT_W'(1);
            end else begin
                hazard_count_d = hazard_count_q;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q        <= '0;
            regw_q         <= '0;
            load_q         <= '0;
            rd_q           <= '0;
            hazard_count_q <= '0;
        end else begin
            valid_q        <= valid_d;
            regw_q         <= regw_d;
            load_q         <= load_d;
            rd_q           <= rd_d;
            hazard_count_q <= hazard_count_d;
        end
    end

    assign fwd_sel      = fwd_sel_s;
    assign hazard_stall = hazard_stall_s;
    assign hazard_count = hazard_count_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Self-checking bench for forward_scoreboard: directed scenarios plus randomized traffic
// compared against a record-list model of the in-flight instructions.
module tb_forward_scoreboard;

    localparam int LOAD_LAT = 1;

    logic        CLK = 1'b0;
    logic        RST;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_regW;
    logic        issue_load;
    logic [9:0]  src_regs;
    logic [1:0]  src_used;
    logic        stall_in;
    logic        flush;
    logic [3:0]  fwd_sel;
    logic        hazard_stall;
    logic [15:0] hazard_count;
    logic [3:0]  fwd_sel_b;
    logic        hazard_stall_b;
    logic [1:0]  hazard_count_b;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed { bit v; bit [4:0] rd; bit w; bit ld; } rec_t;
    rec_t pipe [3];
    int   cnt;
    int   cnt2;

    always #5 CLK = ~CLK;

    forward_scoreboard dut (
        .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_regW(issue_regW), .issue_load(issue_load), .src_regs(src_regs),
        .src_used(src_used), .stall_in(stall_in), .flush(flush),
        .fwd_sel(fwd_sel), .hazard_stall(hazard_stall), .hazard_count(hazard_count)
    );

    forward_scoreboard #(.CNT_W(2)) dut_b (
        .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_regW(issue_regW), .issue_load(issue_load), .src_regs(src_regs),
        .src_used(src_used), .stall_in(stall_in), .flush(flush),
        .fwd_sel(fwd_sel_b), .hazard_stall(hazard_stall_b), .hazard_count(hazard_count_b)
    );

    wire [22:0] obs = {fwd_sel, hazard_stall, hazard_count, hazard_count_b};

    // Expected select for operand k: 0 = register file, j+1 = bypass, -1 = must wait
    function automatic int msel(input int k);
        logic [4:0] s;
        s = src_regs[k*5 +: 5];
        if (!src_used[k] || s == 5'd0) return 0;
        for (int j = 0; j < 3; j++) begin
            if (pipe[j].v && pipe[j].w && pipe[j].rd == s) begin
                if (pipe[j].ld && j < LOAD_LAT) return -1;
                return j + 1;
            end
        end
        return 0;
    endfunction

    function automatic bit mstall();
        return issue_valid && !flush && (msel(0) < 0 || msel(1) < 0);
    endfunction

    function automatic logic [22:0] exp_obs();
        logic [1:0] s0, s1;
        s0 = (msel(0) < 0) ? 2'd0 : 2'(msel(0));
        s1 = (msel(1) < 0) ? 2'd0 : 2'(msel(1));
        return {s1, s0, mstall(), 16'(cnt), 2'(cnt2)};
    endfunction

    task automatic tick();
        bit hz;
        hz = mstall();
        if (RST) begin
            for (int j = 0; j < 3; j++) pipe[j] = '0;
            cnt  = 0;
            cnt2 = 0;
        end else if (stall_in) begin
            if (flush) pipe[0].v = 1'b0;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{v: issue_valid && !hz && !flush, rd: issue_rd, w: issue_regW, ld: issue_load};
            if (hz) begin
                if (cnt < 65535) cnt++;
                if (cnt2 < 3) cnt2++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit v, input logic [4:0] rd, input bit w, input bit ld,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
        issue_valid = v;
        issue_rd    = rd;
        issue_regW  = w;
        issue_load  = ld;
        src_regs    = {s1, s0};
        src_used    = used;
        stall_in    = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1, 7, 1, 1, 8, 9, 2'b11);
        #1;
        n_total++;
        if (obs !== 23'd0) $display("FAIL reset_state: got %h expected 0", obs);
        else n_pass++;
    endtask

    task automatic test_forward();
        do_reset();
        drive(1, 8, 1, 0, 0, 0, 0);
        tick();
        drive(1, 10, 1, 0, 8, 0, 2'b01);
        #1;
        n_total++;
        if (fwd_sel !== 4'b0001 || hazard_stall !== 1'b0 || obs !== exp_obs())
            $display("FAIL forward_ex: got %h expected sel 1 (%h)", obs, exp_obs());
        else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 9, 1, 1, 0, 0, 0);
        tick();
        drive(1, 11, 1, 0, 0, 9, 2'b10);
        #1;
        n_total++;
        if (hazard_stall !== 1'b1 || fwd_sel !== 4'd0 || obs !== exp_obs())
            $display("FAIL load_use_stall: got %h expected stall (%h)", obs, exp_obs());
        else n_pass++;
        tick();
        n_total++;
        if (fwd_sel !== 4'b1000 || hazard_stall !== 1'b0 || hazard_count !== 16'd1 || obs !== exp_obs())
            $display("FAIL load_use_resolve: got %h expected sel1=2 count 1 (%h)", obs, exp_obs());
        else n_pass++;
    endtask

    task automatic test_youngest();
        logic [3:0] want [3];
        want[0] = 4'd1; want[1] = 4'd3; want[2] = 4'd0;
        do_reset();
        drive(1, 5, 1, 0, 0, 0, 0);
        tick();
        drive(1, 5, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 5, 0, 2'b01);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (i != 1) begin
                n_total++;
                if (fwd_sel !== want[(i == 0) ? 0 : i - 1] || obs !== exp_obs())
                    $display("FAIL youngest_age%0d: got %h expected sel %0d (%h)", i, obs,
                             want[(i == 0) ? 0 : i - 1], exp_obs());
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_zero_unused();
        do_reset();
        drive(1, 0, 1, 0, 0, 0, 0);
        tick();
        drive(1, 6, 1, 0, 0, 0, 2'b11);
        #1;
        n_total++;
        if (fwd_sel !== 4'd0 || obs !== exp_obs())
            $display("FAIL r0_not_tracked: got %h expected sel 0", obs);
        else n_pass++;
        tick();
        drive(1, 12, 1, 0, 6, 6, 2'b00);
        #1;
        n_total++;
        if (fwd_sel !== 4'd0 || hazard_stall !== 1'b0 || obs !== exp_obs())
            $display("FAIL unused_operand: got %h expected sel 0 no stall", obs);
        else n_pass++;
        src_used = 2'b11;
        #1;
        n_total++;
        if (fwd_sel !== 4'b0101 || obs !== exp_obs())
            $display("FAIL same_reg_both_ops: got %h expected sel 5", obs);
        else n_pass++;
    endtask

    task automatic test_stall_flush();
        do_reset();
        drive(1, 9, 1, 1, 0, 0, 0);
        tick();
        drive(1, 10, 1, 0, 9, 0, 2'b01);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (hazard_stall !== 1'b1 || hazard_count !== 16'd0 || obs !== exp_obs())
                $display("FAIL stall_in_hold%0d: got %h expected %h", i, obs, exp_obs());
            else n_pass++;
        end
        flush = 1'b1;
        #1;
        n_total++;
        if (hazard_stall !== 1'b0 || obs !== exp_obs())
            $display("FAIL flush_beats_hazard: got %h expected stall 0", obs);
        else n_pass++;
        tick();
        flush    = 1'b0;
        stall_in = 1'b0;
        #1;
        n_total++;
        if (fwd_sel !== 4'd0 || hazard_stall !== 1'b0 || obs !== exp_obs())
            $display("FAIL flush_in_stall_kills_e0: got %h expected %h", obs, exp_obs());
        else n_pass++;
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 3, 1, 1, 0, 0, 0);
            tick();
            drive(1, 4, 1, 0, 3, 0, 2'b01);
            tick();
            tick();
        end
        #1;
        n_total++;
        if (hazard_count_b !== 2'd3 || hazard_count !== 16'd4 || obs !== exp_obs())
            $display("FAIL counter_saturate: got %h expected counts 4/3", obs);
        else n_pass++;
        drive(1, 3, 1, 1, 0, 0, 0);
        tick();
        drive(1, 4, 1, 0, 3, 0, 2'b01);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        n_total++;
        if (obs !== 23'd0)
            $display("FAIL reset_mid_hazard: got %h expected 0", obs);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 4) != 0,
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)));
            stall_in = $urandom_range(0, 6) == 0;
            flush    = $urandom_range(0, 9) == 0;
            RST      = $urandom_range(0, 49) == 0;
            #1;
            if (!RST) begin
                n_total++;
                if (obs !== exp_obs())
                    $display("FAIL random_cycle%0d: got %h expected %h", i, obs, exp_obs());
                else n_pass++;
            end
            tick();
        end
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b0;
        cnt = 0;
        cnt2 = 0;
        for (int j = 0; j < 3; j++) pipe[j] = '0;
        drive(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_forward();
        test_load_use();
        test_youngest();
        test_zero_unused();
        test_stall_flush();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
